bps_serial_sub_ctrl: RTL

//   Nibble-serial multi-precision subtraction controller around one 4-bit

---
 rtl/bps_serial_sub_ctrl_pkg.sv | 13 +
 rtl/bps_serial_sub_ctrl_if.sv | 30 +++
 rtl/bps_serial_sub_ctrl_bps.sv | 21 ++
 rtl/bps_serial_sub_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/bps_serial_sub_ctrl_pkg.sv
// Shared definitions for the nibble-serial subtraction controller:
// slice width and FSM state encoding.
package bps_serial_sub_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bps_serial_sub_ctrl_if.sv
// Requester-side handshake and operand/result bundle for bps_serial_sub_ctrl.
interface bps_serial_sub_ctrl_if
  import bps_serial_sub_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         bin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;

  modport master (
    output start, op_a, op_b, bin,
    input  ready, busy, done, diff, bout, zero
  );

  modport slave (
    input  start, op_a, op_b, bin,
    output ready, busy, done, diff, bout, zero
  );

endinterface

// File: rtl/bps_serial_sub_ctrl_bps.sv
// 4-bit borrow-propagate subtractor slice: d = a - b - boin, boout = borrow.
module bps
  import bps_serial_sub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                boin,
  output logic [NIBBLE_W-1:0] d,
  output logic                boout
);

  logic [NIBBLE_W:0] t;

  // One extra bit on the left catches the borrow out of the slice.
  always_comb begin
    t     = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, boin};
    d     = t[NIBBLE_W-1:0];
    boout = t[NIBBLE_W];
  end

endmodule

// File: rtl/bps_serial_sub_ctrl.sv
// Nibble-serial multi-precision subtractor: one bps slice, LSB nibble first,
// borrow chained through a register, start/done handshake to the requester.
module bps_serial_sub_ctrl
  import bps_serial_sub_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
)(
  input  logic                 clk,
  input  logic                 rst,
  bps_serial_sub_ctrl_if.slave bus
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               brw_q, brw_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               zero_q, zero_d;

  logic [NIBBLE_W-1:0] a_nib, b_nib, d_nib;
  logic                bo_nib;

  bps u_bps (
    .a     (a_nib),
    .b     (b_nib),
    .boin  (brw_q),
    .d     (d_nib),
    .boout (bo_nib)
  );

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      brw_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      brw_q   <= brw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  // Select the current operand nibble pair for the slice.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    brw_d   = brw_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          brw_d   = bus.bin;
          idx_d   = '0;
          diff_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) diff_d[i*NIBBLE_W +: NIBBLE_W] = d_nib;
        end
        brw_d = bo_nib;
        if (idx_q == LAST_IDX) begin
          // zero is taken from the fully assembled next diff, not diff_q.
          bout_d  = bo_nib;
          zero_d  = (diff_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; results straight from registers.
  always_comb begin
    bus.ready = (state_q == ST_IDLE);
    bus.busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    bus.done  = (state_q == ST_DONE);
    bus.diff  = diff_q;
    bus.bout  = bout_q;
    bus.zero  = zero_q;
  end

endmodule
